// File: rtl/filt_pkg.sv
// Shared definitions for the lowpass filter output path.
package filt_pkg;

  localparam int SAMPLE_W = 16;

  // Serial transmitter states; explicit encoding keeps the legacy bit values.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_t;

endpackage

// File: rtl/sample_fifo2.sv
// Two-entry first-in first-out buffer with occupancy count.
// Push is ignored when full and pop is ignored when empty.
module sample_fifo2
  import filt_pkg::*;
#(
  parameter int W = SAMPLE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop && (count != 2'd0);
  assign dout    = head;

  // Head always holds the oldest word; tail only used when two are stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) head <= din;
          else               tail <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop only happens with one word stored.
          head <= din;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sample_serial_tx.sv
// Serial transmitter for filtered samples: buffers words in a 2-entry FIFO
// and shifts each one out MSB-first on sclk/sdata with a frame sync on the MSB.
module sample_serial_tx
  import filt_pkg::*;
#(
  parameter int DATA_W  = SAMPLE_W,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              sclk,
  output logic              sdata,
  output logic              fs,
  output logic              busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BC_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  tx_state_t         state;
  tx_state_t         state_nx;
  logic [DIV_W-1:0]  div;
  logic [BC_W-1:0]   bitcnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] fifo_dout;
  logic [1:0]        count;
  logic              fifo_ne;
  logic              push;
  logic              pop;
  logic              tick;
  logic              fall;
  logic              last_bit;
  logic              busy_nx;

  sample_fifo2 #(.W(DATA_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (s_data),
    .dout  (fifo_dout),
    .count (count)
  );

  assign fifo_ne  = (count != 2'd0);
  assign s_ready  = rst_n && (count != 2'd2);
  assign push     = s_valid && s_ready;
  assign tick     = (state == SHIFT) && (div == DIV_W'(CLK_DIV - 1));
  assign fall     = tick && sclk;
  assign last_bit = (bitcnt == BC_W'(DATA_W - 1));
  assign pop      = fifo_ne && ((state == IDLE) || (fall && last_bit));

  // Registered busy: a word landing in an idle FIFO only raises busy once it is
  // popped, while a push coinciding with the return to IDLE keeps busy high.
  assign busy_nx = (state_nx == SHIFT) || ((state == SHIFT) && push);

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (fifo_ne) state_nx = SHIFT;
      SHIFT:   if (fall && last_bit && !fifo_ne) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM, sclk divider, bit counter and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      div    <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      sclk   <= 1'b0;
      sdata  <= 1'b0;
      fs     <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= busy_nx;
      case (state)
        IDLE: begin
          div  <= '0;
          sclk <= 1'b0;
          if (fifo_ne) begin
            shreg  <= fifo_dout;
            sdata  <= fifo_dout[DATA_W-1];
            fs     <= 1'b1;
            bitcnt <= '0;
          end else begin
            sdata <= 1'b0;
            fs    <= 1'b0;
          end
        end
        SHIFT: begin
          if (tick) begin
            div  <= '0;
            sclk <= ~sclk;
          end else begin
            div <= div + DIV_W'(1);
          end
          if (fall) begin
            if (!last_bit) begin
              shreg  <= shreg << 1;
              sdata  <= shreg[DATA_W-2];
              bitcnt <= bitcnt + BC_W'(1);
              fs     <= 1'b0;
            end else if (fifo_ne) begin
              shreg  <= fifo_dout;
              sdata  <= fifo_dout[DATA_W-1];
              bitcnt <= '0;
              fs     <= 1'b1;
            end else begin
              sdata  <= 1'b0;
              fs     <= 1'b0;
              bitcnt <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_serial_tx.sv
// Bench for sample_serial_tx: table-driven single frames, hand-written burst,
// backpressure and reset sequences, and randomized traffic against a queue model.
module tb_sample_serial_tx;

  localparam int DW = 16;
  localparam int CD = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready, sclk, sdata, fs, busy;
  logic [DW-1:0] s_data2 = '0;
  logic          s_valid2 = 1'b0;
  logic          s_ready2, sclk2, sdata2, fs2, busy2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  sample_serial_tx #(.DATA_W(DW), .CLK_DIV(CD)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .sclk(sclk), .sdata(sdata), .fs(fs), .busy(busy)
  );

  sample_serial_tx #(.DATA_W(DW), .CLK_DIV(1)) dut_div1 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data2), .s_valid(s_valid2),
    .s_ready(s_ready2), .sclk(sclk2), .sdata(sdata2), .fs(fs2), .busy(busy2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: words accepted by the handshake must appear, in order,
  // as DW-bit MSB-first frames sampled on sclk rises, with fs only on bit 0.
  logic [DW-1:0] expq[$];
  int            bitpos = 0;
  logic [DW-1:0] word = '0;
  logic          prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      bitpos    = 0;
      prev_sclk = 1'b0;
    end else begin
      if (s_valid && s_ready) expq.push_back(s_data);
      if (sclk && !prev_sclk) begin
        chk("mon_fs", fs, (bitpos == 0));
        word = {word[DW-2:0], sdata};
        bitpos++;
        if (bitpos == DW) begin
          bitpos = 0;
          if (expq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL mon_word: got %0h expected no frame", word);
          end else begin
            chk("mon_word", word, expq.pop_front());
          end
        end
      end
      prev_sclk = sclk;
    end
  end

  task automatic wait_idle(input int limit);
    int k;
    for (k = 0; k < limit; k++) begin
      if (!busy && !busy2) break;
      step();
    end
    if (k == limit) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: got busy after %0d cycles expected idle", limit);
    end
  endtask

  // Send one word into an idle DUT (sel picks the instance) and measure the frame.
  task automatic send_measure(input int sel, input logic [DW-1:0] d,
                              output int fs_c, output int rises, output int busy_c,
                              output int first_rise, output int toggles,
                              output int ones, output logic msb);
    logic ps, m_fs, m_sclk, m_sdata, m_busy, done;
    fs_c = 0; rises = 0; busy_c = 0; first_rise = 0; toggles = 0; ones = 0; msb = 1'b0;
    done = 1'b0;
    ps = 1'b0;
    if (sel == 0) begin
      chk("idle_ready", s_ready, 1);
      s_data = d; s_valid = 1'b1;
    end else begin
      chk("idle_ready_div1", s_ready2, 1);
      s_data2 = d; s_valid2 = 1'b1;
    end
    step();
    s_valid = 1'b0;
    s_valid2 = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      step();
      m_fs    = (sel == 0) ? fs    : fs2;
      m_sclk  = (sel == 0) ? sclk  : sclk2;
      m_sdata = (sel == 0) ? sdata : sdata2;
      m_busy  = (sel == 0) ? busy  : busy2;
      if (k == 1) msb = m_sdata;
      if (m_fs) fs_c++;
      if (m_sclk != ps) toggles++;
      if (m_sclk && !ps) begin
        rises++;
        if (first_rise == 0) first_rise = k;
        if (m_sdata) ones++;
      end
      if (m_busy) busy_c++;
      ps = m_sclk;
      if (!m_busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL frame_timeout: got busy after 300 cycles expected idle");
    end
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          exp_msb;
    int            exp_ones;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int fs_c, rises, busy_c, first_rise, toggles, ones;
    logic msb, rdy, pfs, accepted;
    int hold, nfs, t0, rcount;
    int fs_t[3];
    logic [DW-1:0] rw;

    vecs[0] = '{16'h8001, 1'b1, 2};
    vecs[1] = '{16'h7FFE, 1'b0, 14};
    vecs[2] = '{16'h0000, 1'b0, 0};
    vecs[3] = '{16'hFFFF, 1'b1, 16};
    vecs[4] = '{16'h5555, 1'b0, 8};
    vecs[5] = '{16'hC3A0, 1'b1, 6};

    // Reset state
    step(); step();
    chk("rst_sclk", sclk, 0);
    chk("rst_sdata", sdata, 0);
    chk("rst_fs", fs, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", s_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", s_ready, 1);
    chk("ready_after_rst_div1", s_ready2, 1);
    step();

    // Single-word frames at CLK_DIV = 2
    foreach (vecs[i]) begin
      send_measure(0, vecs[i].data, fs_c, rises, busy_c, first_rise, toggles, ones, msb);
      chk("vec_msb", msb, vecs[i].exp_msb);
      chk("vec_fs_cycles", fs_c, 4);
      chk("vec_rises", rises, 16);
      chk("vec_toggles", toggles, 32);
      chk("vec_busy_cycles", busy_c, 64);
      chk("vec_first_rise", first_rise, 1 + CD);
      chk("vec_ones", ones, vecs[i].exp_ones);
      chk("vec_busy_end", busy, 0);
      step(); step();
    end

    // Burst of three words, then a fourth held off by a full FIFO
    wait_idle(200);
    s_valid = 1'b1; s_data = 16'hA5A5;
    chk("burst_rdy0", s_ready, 1);
    step();
    chk("burst_rdy1", s_ready, 1);
    s_data = 16'h0001;
    step();
    chk("burst_fs_first", fs, 1);
    chk("burst_msb_first", sdata, 1);
    t0 = cyc;
    chk("burst_rdy2", s_ready, 1);
    s_data = 16'hFFFF;
    step();
    s_data = 16'h1234;
    hold = 0; nfs = 0; pfs = fs; accepted = 1'b0;
    fs_t[0] = 0; fs_t[1] = 0; fs_t[2] = 0;
    for (int k = 0; k < 700; k++) begin
      rdy = s_ready;
      step();
      if (s_valid) begin
        if (rdy) begin
          s_valid = 1'b0;
          accepted = 1'b1;
        end else begin
          hold++;
        end
      end
      if (fs && !pfs) begin
        if (nfs < 3) fs_t[nfs] = cyc - t0;
        nfs++;
      end
      pfs = fs;
      if (!busy) break;
    end
    chk("bp_accepted", accepted, 1);
    chk("bp_hold_cycles", hold, 63);
    chk("burst_fs_count", nfs, 3);
    chk("burst_fs_t1", fs_t[0], 64);
    chk("burst_fs_t2", fs_t[1], 128);
    chk("burst_fs_t3", fs_t[2], 192);
    chk("burst_busy_end", busy, 0);
    chk("burst_drain", expq.size(), 0);
    step();

    // Reset in the middle of a frame (bit 7 of 7FFF)
    s_valid = 1'b1; s_data = 16'h7FFF;
    step();
    s_valid = 1'b0;
    rcount = 0; pfs = 1'b0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (sclk && !pfs) rcount++;
      pfs = sclk;
      if (rcount == 8) break;
    end
    chk("prerst_rises", rcount, 8);
    chk("prerst_sdata", sdata, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sclk", sclk, 0);
    chk("midrst_sdata", sdata, 0);
    chk("midrst_fs", fs, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", s_ready, 0);
    step(); step(); step();
    rst_n = 1'b1;
    #1;
    chk("postrst_ready", s_ready, 1);
    chk("postrst_busy", busy, 0);
    step();
    send_measure(0, 16'h0F0F, fs_c, rises, busy_c, first_rise, toggles, ones, msb);
    chk("postrst_msb", msb, 0);
    chk("postrst_fs_cycles", fs_c, 4);
    chk("postrst_ones", ones, 8);
    chk("postrst_busy_cycles", busy_c, 64);
    step();

    // Randomized traffic with idle gaps
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int g = 0; g < int'($urandom_range(0, 70)); g++) step();
      end
      rw = DW'($urandom);
      s_data = rw;
      s_valid = 1'b1;
      for (int k = 0; k < 300; k++) begin
        rdy = s_ready;
        step();
        if (rdy) break;
      end
      if (s_data == rw && s_valid && !rdy) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rand_accept: got no handshake expected acceptance");
      end
      s_valid = 1'b0;
    end
    wait_idle(2000);
    step(); step();
    chk("rand_drain", expq.size(), 0);
    chk("rand_bitpos", bitpos, 0);

    // CLK_DIV = 1 instance
    send_measure(1, 16'h8000, fs_c, rises, busy_c, first_rise, toggles, ones, msb);
    chk("div1_msb", msb, 1);
    chk("div1_ones", ones, 1);
    chk("div1_fs_cycles", fs_c, 2);
    chk("div1_rises", rises, 16);
    chk("div1_toggles", toggles, 32);
    chk("div1_busy_cycles", busy_c, 32);
    chk("div1_first_rise", first_rise, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
